// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with increment, bus load, stall and hardware
//            call/return through a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         stall,
    input  logic                         incPC,
    input  logic                         enable,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         err_clr,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         ras_udf
);

    localparam int               C_PTR_W = $clog2(RAS_DEPTH);
    localparam int               C_CNT_W = C_PTR_W + 1;
    localparam logic [WIDTH-1:0] C_STEP  = WIDTH'(STEP);
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0]   pc_q,    pc_d;
    logic [C_PTR_W-1:0] ptr_q,   ptr_d;
    logic [C_CNT_W-1:0] cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic               udf_q,   udf_d;
    logic               empty_q, empty_d;
    logic               full_q,  full_d;
    logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [WIDTH-1:0]   ras_d [RAS_DEPTH];

    logic [WIDTH-1:0]   w_pc_inc;
    logic [C_PTR_W-1:0] w_top_idx;
    logic [C_PTR_W-1:0] w_ptr_inc;

    // ptr_q addresses the next free slot; the top of stack sits just below it.
    assign w_pc_inc  = pc_q + C_STEP;
    assign w_top_idx = ptr_q - C_PTR_W'(1);
    assign w_ptr_inc = ptr_q + C_PTR_W'(1);

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        ras_d = ras_q;

        // Clear first so that a flag raised by this cycle's command wins.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (!stall) begin
            if (call && ret) begin
                pc_d = d;
                if (empty_q) begin
                    ras_d[ptr_q] = w_pc_inc;
                    ptr_d        = w_ptr_inc;
                    cnt_d        = C_CNT_W'(1);
                end else begin
                    ras_d[w_top_idx] = w_pc_inc;
                end
            end else if (ret) begin
                if (empty_q) begin
                    pc_d  = w_pc_inc;
                    udf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[w_top_idx];
                    ptr_d = w_top_idx;
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end else if (call) begin
                // When full, ptr_q already points at the oldest entry.
                pc_d         = d;
                ras_d[ptr_q] = w_pc_inc;
                ptr_d        = w_ptr_inc;
                if (full_q) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end else if (enable) begin
                pc_d = d;
            end else if (incPC) begin
                pc_d = w_pc_inc;
            end
        end

        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == C_DEPTH);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q    <= RESET_VAL;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign q         = pc_q;
    assign ras_count = cnt_q;
    assign ras_empty = empty_q;
    assign ras_full  = full_q;
    assign ras_ovf   = ovf_q;
    assign ras_udf   = udf_q;

endmodule
`default_nettype wire
